hp_arbiter: RTL and testbench

HP_ARBITER -- requirements
Module: hp_arbiter

---
 rtl/hp_pkg.sv | 14 +
 rtl/hp_rr_arbiter.sv | 20 ++
 rtl/hp_arbiter.sv | 174 +++++++++++++++++
 tb/tb_hp_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hp_pkg.sv
// Shared types and AXI3 constants for the two-requester AXI arbiter.
package hp_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP, DELIVER} hp_state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Requester i owns ID base|i; base bit 0 is reserved for the requester index.
  function automatic logic [5:0] hp_id(input logic [5:0] base, input logic g);
    return base | {5'd0, g};
  endfunction
endpackage

// File: rtl/hp_rr_arbiter.sv
// Two-way round-robin grant; pointer names the preferred requester.
module hp_rr_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  input  logic       i_adv_gnt,
  output logic       o_any,
  output logic       o_gnt
);
  logic r_ptr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   r_ptr <= 1'b0;
    else if (i_adv) r_ptr <= ~i_adv_gnt;
  end

  assign o_any = |i_req;
  assign o_gnt = i_req[r_ptr] ? r_ptr : ~r_ptr;
endmodule

// File: rtl/hp_arbiter.sv
// Arbitrates two simple requesters onto a single-beat AXI3 master port,
// one transaction outstanding; errors in ID/last are folded into SLVERR.
module hp_arbiter
  import hp_pkg::*;
#(
  parameter logic [5:0] ID_BASE = 6'h00,
  parameter logic [3:0] CACHE   = 4'b0011,
  parameter logic [2:0] PROT    = 3'b000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_write,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_data,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic             rsp_write,
  output logic [1:0]       rsp_resp,
  output logic [31:0]      rsp_data,
  output logic             arvalid,
  input  logic             arready,
  output logic [31:0]      araddr,
  output logic [5:0]       arid,
  output logic [3:0]       arlen,
  output logic [2:0]       arsize,
  output logic [1:0]       arburst,
  output logic [1:0]       arlock,
  output logic [3:0]       arcache,
  output logic [2:0]       arprot,
  output logic [3:0]       arqos,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      awaddr,
  output logic [5:0]       awid,
  output logic [3:0]       awlen,
  output logic [2:0]       awsize,
  output logic [1:0]       awburst,
  output logic [1:0]       awlock,
  output logic [3:0]       awcache,
  output logic [2:0]       awprot,
  output logic [3:0]       awqos,
  output logic             wvalid,
  input  logic             wready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wlast,
  output logic [5:0]       wid,
  input  logic             bvalid,
  output logic             bready,
  input  logic [1:0]       bresp,
  input  logic [5:0]       bid,
  input  logic             rvalid,
  output logic             rready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic [5:0]       rid,
  input  logic             rlast
);
  hp_state_e   r_state, w_next;
  logic        r_write, r_gnt;
  logic [31:0] r_addr, r_data, r_rdata;
  logic [1:0]  r_resp;
  logic        r_ar_pend, r_aw_pend, r_w_pend;
  logic        w_any, w_gnt, w_accept, w_aw_ok, w_w_ok, w_rsp_hs, w_dlv_hs;
  logic [5:0]  w_id;

  hp_rr_arbiter u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_req     (req_valid),
    .i_adv     (w_dlv_hs),
    .i_adv_gnt (r_gnt),
    .o_any     (w_any),
    .o_gnt     (w_gnt)
  );

  assign w_id     = hp_id(ID_BASE, r_gnt);
  assign w_accept = (r_state == IDLE) && w_any;
  assign w_aw_ok  = !r_aw_pend || awready;
  assign w_w_ok   = !r_w_pend || wready;
  assign w_rsp_hs = (r_state == RESP) && (r_write ? bvalid : rvalid);
  assign w_dlv_hs = (r_state == DELIVER) && rsp_ready[r_gnt];

  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    case (r_state)
      IDLE: if (w_any) begin
        w_next = ISSUE;
        if (reset_n) req_ready[w_gnt] = 1'b1;
      end
      ISSUE:   if (r_write ? (w_aw_ok && w_w_ok) : arready) w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = DELIVER;
      DELIVER: if (w_dlv_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_write   <= 1'b0;
      r_gnt     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_ar_pend <= 1'b0;
      r_aw_pend <= 1'b0;
      r_w_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write   <= req_write[w_gnt];
        r_addr    <= req_addr[w_gnt];
        r_data    <= req_data[w_gnt];
        r_gnt     <= w_gnt;
        r_ar_pend <= ~req_write[w_gnt];
        r_aw_pend <= req_write[w_gnt];
        r_w_pend  <= req_write[w_gnt];
      end else if (r_state == ISSUE) begin
        // AW and W retire independently; either may finish first.
        if (arready) r_ar_pend <= 1'b0;
        if (awready) r_aw_pend <= 1'b0;
        if (wready)  r_w_pend  <= 1'b0;
      end
      if (w_rsp_hs) begin
        if (r_write) begin
          r_resp  <= (bid != w_id) ? RESP_SLVERR : bresp;
          r_rdata <= '0;
        end else begin
          r_resp  <= ((rid != w_id) || !rlast) ? RESP_SLVERR : rresp;
          r_rdata <= rdata;
        end
      end
    end
  end

  assign rsp_valid = {2{r_state == DELIVER}} & {r_gnt, ~r_gnt};
  assign rsp_write = r_write;
  assign rsp_resp  = r_resp;
  assign rsp_data  = r_rdata;

  assign arvalid = r_ar_pend;
  assign araddr  = r_addr;
  assign arid    = w_id;
  assign awvalid = r_aw_pend;
  assign awaddr  = r_addr;
  assign awid    = w_id;
  assign wvalid  = r_w_pend;
  assign wdata   = r_data;
  assign wstrb   = 4'hF;
  assign wlast   = r_w_pend;
  assign wid     = w_id;
  assign bready  = (r_state == RESP) && r_write;
  assign rready  = (r_state == RESP) && !r_write;

  assign arlen   = 4'd0;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = CACHE;
  assign arprot  = PROT;
  assign arqos   = 4'd0;
  assign awlen   = 4'd0;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = CACHE;
  assign awprot  = PROT;
  assign awqos   = 4'd0;
endmodule

// File: tb/tb_hp_arbiter.sv
// Scoreboard bench for hp_arbiter: requester driver, reactive AXI slave, response monitor.
module tb_hp_arbiter;
  localparam logic [5:0] ID_BASE = 6'h00;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic             reset_n;
  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_ready;
  logic [1:0][31:0] req_addr, req_data;
  logic             rsp_write;
  logic [1:0]       rsp_resp;
  logic [31:0]      rsp_data;
  logic             arvalid, arready, awvalid, awready, wvalid, wready, wlast;
  logic [31:0]      araddr, awaddr, wdata, rdata;
  logic [5:0]       arid, awid, wid, bid, rid;
  logic [3:0]       arlen, awlen, arcache, awcache, arqos, awqos, wstrb;
  logic [2:0]       arsize, awsize, arprot, awprot;
  logic [1:0]       arburst, awburst, arlock, awlock, bresp, rresp;
  logic             bvalid, bready, rvalid, rready, rlast;

  hp_arbiter #(.ID_BASE(ID_BASE), .CACHE(4'b0011), .PROT(3'b000)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast)
  );

  typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct {logic wr; logic [1:0] resp; logic [31:0] data;} exp_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  req_t rq0[$], rq1[$];
  exp_t ex0[$], ex1[$];
  int   grant_log[$];
  logic [1:0]  pres;
  int   pres_pct = 100;
  int   last_acc_cyc = -10, last_rsp_cyc = -10;
  logic        last_gnt = 1'b0;
  logic [31:0] last_acc_addr = '0, last_acc_data = '0;
  logic        hold_ar = 1'b0, aw_lag = 1'b0, rsp_hold = 1'b0;
  logic [31:0] mem0 [logic [31:0]];
  logic [31:0] mem1 [logic [31:0]];
  logic [31:0] smem [logic [32:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave personality: default memory contents and response code chosen by addr[5:4].
  function automatic logic [31:0] dflt(input logic r, input logic [31:0] a);
    return a ^ 32'hCEADBEAF ^ (r ? 32'h0F0F0000 : 32'h0);
  endfunction

  function automatic logic [1:0] exp_resp(input logic wr, input logic [31:0] a);
    case (a[5:4])
      2'b00:   return 2'b00;
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      default: return wr ? 2'b11 : 2'b10;
    endcase
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.wr   = 1'($urandom_range(1));
    r.addr = 32'h3000_0000 | ($urandom & 32'h0000_0FFC);
    r.data = $urandom;
    return r;
  endfunction

  // Requester driver: presents queued requests, predicts responses on acceptance.
  initial begin : drv
    logic [1:0] hs;
    int   smp;
    req_t cur [2];
    exp_t e;
    req_valid = '0; req_write = '0; req_addr = '0; req_data = '0; pres = '0;
    forever begin
      @(negedge clock);
      hs  = req_valid & req_ready;
      smp = cyc;
      @(posedge clock); #1;
      if (!reset_n) begin
        pres = '0; req_valid = '0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (hs[i]) begin
            e.wr   = cur[i].wr;
            e.resp = exp_resp(cur[i].wr, cur[i].addr);
            e.data = 32'h0;
            if (i == 0) begin
              if (cur[i].wr) mem0[cur[i].addr] = cur[i].data;
              else e.data = mem0.exists(cur[i].addr) ? mem0[cur[i].addr] : dflt(1'b0, cur[i].addr);
              ex0.push_back(e);
            end else begin
              if (cur[i].wr) mem1[cur[i].addr] = cur[i].data;
              else e.data = mem1.exists(cur[i].addr) ? mem1[cur[i].addr] : dflt(1'b1, cur[i].addr);
              ex1.push_back(e);
            end
            grant_log.push_back(i);
            last_gnt = 1'(i); last_acc_cyc = smp;
            last_acc_addr = cur[i].addr; last_acc_data = cur[i].data;
            pres[i] = 1'b0; req_valid[i] = 1'b0;
          end
          if (!pres[i] && ((i == 0) ? rq0.size() : rq1.size()) != 0 &&
              $urandom_range(99) < pres_pct) begin
            cur[i] = (i == 0) ? rq0.pop_front() : rq1.pop_front();
            pres[i] = 1'b1; req_valid[i] = 1'b1;
            req_write[i] = cur[i].wr; req_addr[i] = cur[i].addr; req_data[i] = cur[i].data;
          end
        end
      end
    end
  end

  // Reactive single-beat AXI slave with random handshake and response delays.
  initial begin : slv
    logic s_ar, s_aw, s_w, s_b, s_r, prev_arv, prev_awv;
    logic got_aw, got_w, have_r, have_b;
    logic [31:0] s_araddr, s_awaddr, s_wdata, rd_a, wr_a, wr_d;
    logic [5:0]  s_arid, s_awid, rd_i, wr_i;
    logic [32:0] k;
    int dly, w_cyc;
    arready = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; bid = 0; rdata = 0; rresp = 0; rid = 0; rlast = 0;
    got_aw = 0; got_w = 0; have_r = 0; have_b = 0; dly = 0; w_cyc = 0;
    prev_arv = 0; prev_awv = 0;
    rd_a = 0; wr_a = 0; wr_d = 0; rd_i = 0; wr_i = 0;
    forever begin
      @(negedge clock);
      s_ar = arvalid & arready; s_aw = awvalid & awready; s_w = wvalid & wready;
      s_b = bvalid & bready; s_r = rvalid & rready;
      s_araddr = araddr; s_arid = arid; s_awaddr = awaddr; s_awid = awid; s_wdata = wdata;
      if (reset_n) begin
        if (arvalid && !prev_arv) chk("ar_first_cycle", 64'(cyc), 64'(last_acc_cyc + 1));
        if (awvalid && !prev_awv) chk("aw_first_cycle", 64'(cyc), 64'(last_acc_cyc + 1));
        if (arvalid | awvalid | wvalid)
          chk("single_outstanding", {have_r, have_b, rvalid, bvalid}, 0);
        if (bready) chk("bready_after_both", got_aw ^ got_w, 0);
        if (s_ar) begin
          chk("arid", s_arid, ID_BASE | {5'd0, last_gnt});
          chk("araddr", s_araddr, last_acc_addr);
        end
        if (s_aw) begin
          chk("awid", s_awid, ID_BASE | {5'd0, last_gnt});
          chk("awaddr", s_awaddr, last_acc_addr);
        end
        if (s_w) begin
          chk("wdata", s_wdata, last_acc_data);
          chk("wid_wstrb_wlast", {wid, wstrb, wlast}, {ID_BASE | {5'd0, last_gnt}, 4'hF, 1'b1});
        end
        if (s_b || s_r) last_rsp_cyc = cyc;
      end
      prev_arv = arvalid; prev_awv = awvalid;
      @(posedge clock); #1;
      if (!reset_n) begin
        got_aw = 0; got_w = 0; have_r = 0; have_b = 0;
        arready = 0; awready = 0; wready = 0; bvalid = 0; rvalid = 0;
      end else begin
        if (s_ar) begin have_r = 1; rd_a = s_araddr; rd_i = s_arid; dly = $urandom_range(3); end
        if (s_aw) begin got_aw = 1; wr_a = s_awaddr; wr_i = s_awid; end
        if (s_w)  begin got_w = 1; wr_d = s_wdata; w_cyc = cyc; end
        if (got_aw && got_w) begin
          smem[{wr_i[0], wr_a}] = wr_d;
          have_b = 1; got_aw = 0; got_w = 0; dly = $urandom_range(3);
        end
        if (s_r) rvalid = 0;
        if (s_b) bvalid = 0;
        if (have_r && !rvalid) begin
          if (dly > 0) dly--;
          else begin
            k = {rd_i[0], rd_a};
            rvalid = 1; have_r = 0;
            rdata = smem.exists(k) ? smem[k] : dflt(k[32], k[31:0]);
            rid   = (rd_a[5:4] == 2'b10) ? (rd_i ^ 6'h05) : rd_i;
            rlast = (rd_a[5:4] != 2'b11);
            rresp = (rd_a[5:4] == 2'b01) ? 2'b01 : 2'b00;
          end
        end
        if (have_b && !bvalid) begin
          if (dly > 0) dly--;
          else begin
            bvalid = 1; have_b = 0;
            bid   = (wr_a[5:4] == 2'b10) ? (wr_i ^ 6'h05) : wr_i;
            bresp = (wr_a[5:4] == 2'b01) ? 2'b01 : (wr_a[5:4] == 2'b11) ? 2'b11 : 2'b00;
          end
        end
        arready = !hold_ar && ($urandom_range(2) != 0);
        wready  = ($urandom_range(2) != 0);
        awready = aw_lag ? (got_w && (cyc - w_cyc >= 3)) : ($urandom_range(2) != 0);
      end
    end
  end

  // Response monitor: pops per-requester scoreboards, checks handshake rules.
  initial begin : mon
    exp_t e;
    logic [1:0]  prev_v;
    logic [34:0] prev_f;
    rsp_ready = '0; prev_v = '0; prev_f = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        ex0.delete(); ex1.delete(); prev_v = '0;
      end else begin
        if (req_ready != 0) begin
          chk("req_ready_onehot", 64'($countones(req_ready)), 1);
          chk("req_ready_subset", req_ready & ~req_valid, 0);
        end
        if (rsp_valid != 0) begin
          chk("rsp_valid_onehot", 64'($countones(rsp_valid)), 1);
          chk("req_ready_while_deliver", req_ready, 0);
          if (prev_v == 0) chk("rsp_latency", 64'(cyc), 64'(last_rsp_cyc + 1));
          else chk("rsp_stable", {rsp_valid, rsp_write, rsp_resp, rsp_data}, {prev_v, prev_f});
        end
        for (int i = 0; i < 2; i++) begin
          if (rsp_valid[i] && rsp_ready[i]) begin
            chk("rsp_has_expectation", 64'((i == 0) ? ex0.size() : ex1.size()) != 0, 1);
            if (((i == 0) ? ex0.size() : ex1.size()) != 0) begin
              e = (i == 0) ? ex0.pop_front() : ex1.pop_front();
              chk($sformatf("rsp%0d_write", i), rsp_write, e.wr);
              chk($sformatf("rsp%0d_resp", i), rsp_resp, e.resp);
              chk($sformatf("rsp%0d_data", i), rsp_data, e.data);
            end
          end
        end
        prev_v = rsp_valid & ~rsp_ready;
        prev_f = {rsp_write, rsp_resp, rsp_data};
      end
      @(posedge clock); #1;
      rsp_ready = rsp_hold ? 2'b00 : {1'($urandom_range(2) != 0), 1'($urandom_range(2) != 0)};
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && pres == 0 && ex0.size() == 0 &&
             ex1.size() == 0) && n < budget) begin
      @(negedge clock); n++;
    end
    chk("idle_within_budget", 64'(n < budget), 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_sig(input string nm, input int which, input int budget);
    int n = 0;
    while (n < budget && !((which == 0) ? rsp_valid[0] : (arvalid | awvalid))) begin
      @(negedge clock); n++;
    end
    chk(nm, 64'(n < budget), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    req_t r;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_axi_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("rst_req_rsp", {req_ready, rsp_valid}, 0);
    chk("rst_fields", {araddr, rsp_data, rsp_resp, rsp_write}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("const_ar", {arlen, arsize, arburst, arlock, arcache, arprot, arqos},
        {4'd0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'd0});
    chk("const_aw", {awlen, awsize, awburst, awlock, awcache, awprot, awqos},
        {4'd0, 3'b010, 2'b01, 2'b00, 4'b0011, 3'b000, 4'd0});

    // Both requesters continuously valid: grants alternate from requester 0.
    grant_log.delete();
    for (int k = 0; k < 2; k++) begin
      r = rnd_req(); r.wr = 0; rq0.push_back(r);
      r = rnd_req(); r.wr = 0; rq1.push_back(r);
    end
    wait_idle(2000);
    chk("alt_grant_count", 64'(grant_log.size()), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      chk($sformatf("alt_grant_%0d", k), 64'(grant_log[k]), 64'(k % 2));

    r.wr = 0; r.addr = 32'h1000_0040; r.data = 0; rq0.push_back(r);
    wait_idle(500);

    // Write with awready three cycles after the W handshake, then read back.
    aw_lag = 1'b1;
    r.wr = 1; r.addr = 32'h2000_0000; r.data = 32'h1234_5600; rq1.push_back(r);
    wait_idle(500);
    aw_lag = 1'b0;
    r.wr = 0; r.data = 0; rq1.push_back(r);
    wait_idle(500);

    r.wr = 0; r.addr = 32'h1000_0020; rq0.push_back(r);
    wait_idle(500);

    // Response held off for 10 cycles with the other requester waiting.
    rsp_hold = 1'b1;
    r = rnd_req(); r.wr = 0; rq0.push_back(r);
    wait_sig("rsp_valid_seen", 0, 500);
    r = rnd_req(); rq1.push_back(r);
    repeat (10) @(negedge clock);
    rsp_hold = 1'b0;
    wait_idle(500);

    pres_pct = 60;
    for (int k = 0; k < 80; k++) begin
      r = rnd_req();
      if ($urandom_range(1) == 0) rq0.push_back(r); else rq1.push_back(r);
    end
    wait_idle(20000);
    pres_pct = 100;

    // Reset during ISSUE with the pointer favouring requester 1.
    r = rnd_req(); r.wr = 0; rq0.push_back(r);
    wait_idle(500);
    hold_ar = 1'b1;
    r = rnd_req(); r.wr = 0; rq1.push_back(r);
    wait_sig("issue_seen", 1, 500);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_axi", {arvalid, awvalid, wvalid, bready, rready}, 0);
    chk("async_rst_req_rsp", {req_ready, rsp_valid}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    hold_ar = 1'b0;
    repeat (6) @(negedge clock);
    grant_log.delete();
    r = rnd_req(); rq0.push_back(r);
    r = rnd_req(); rq1.push_back(r);
    wait_idle(1000);
    chk("post_rst_grant_count", 64'(grant_log.size()), 2);
    if (grant_log.size() != 0) chk("post_rst_first_grant", 64'(grant_log[0]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
